// File: rtl/pn_eval_pkg.sv
// pn_eval_pkg: opcodes, FSM states and token layout shared by the evaluator
package pn_eval_pkg;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;
  localparam int TOK_W = 32;
  typedef enum logic [1:0] {IDLE, LOAD, EVAL, DONE} state_t;
  typedef struct packed {
    logic operator;
    logic [TOK_W-1:0] value;
  } tok_t;
endpackage

// File: rtl/pn_stack.sv
// pn_stack: OUT_W x MAX_LEN LIFO with push, pop2-and-replace, depth and error flags
module pn_stack #(
  parameter int OUT_W = 64,
  parameter int MAX_LEN = 20,
  localparam int DW = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop2,
  input  logic [OUT_W-1:0] wdata,
  output logic [OUT_W-1:0] top,
  output logic [OUT_W-1:0] nxt,
  output logic [DW-1:0]    depth,
  output logic             udf,
  output logic             ovf
);
  logic [OUT_W-1:0] mem_q [MAX_LEN];
  logic [OUT_W-1:0] mem_d [MAX_LEN];
  logic [DW-1:0] depth_q, depth_d;
  assign depth = depth_q;
  assign top = depth_q != '0 ? mem_q[depth_q - DW'(1)] : '0;
  assign nxt = depth_q > DW'(1) ? mem_q[depth_q - DW'(2)] : '0;
  assign udf = pop2 && depth_q < DW'(2);
  assign ovf = push && depth_q == DW'(MAX_LEN);
  always_comb begin
    mem_d = mem_q;
    depth_d = depth_q;
    if (push && !ovf) begin
      mem_d[depth_q] = wdata;
      depth_d = depth_q + DW'(1);
    end
    if (pop2 && !udf) begin
      mem_d[depth_q - DW'(2)] = wdata;
      depth_d = depth_q - DW'(1);
    end
    if (clr) depth_d = '0;
  end
  always_ff @(posedge clk) begin
    depth_q <= rst ? '0 : depth_d;
    mem_q <= mem_d;
  end
endmodule

// File: rtl/pn_eval.sv
// pn_eval: buffers a PN token stream then evaluates it prefix or postfix on a stack
module pn_eval import pn_eval_pkg::*; #(
  parameter int DATA_W = 3,
  parameter int OUT_W = 64,
  parameter int MAX_LEN = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in,
  input  logic              operator,
  input  logic              mode,
  output logic              out_valid,
  output logic [OUT_W-1:0]  out,
  output logic              err
);
  localparam int LW = $clog2(MAX_LEN + 1);
  state_t state_q, state_d;
  tok_t tok_q [MAX_LEN];
  tok_t tok_d [MAX_LEN];
  logic [LW-1:0] len_q, len_d, k_q, k_d, idx, depth;
  logic mode_q, mode_d, err_q, err_d, push, pop2, udf, ovf, fin_err;
  logic [OUT_W-1:0] top, nxt, a, b, res, wdata;
  logic [1:0] op;
  tok_t in_tok, cur;
  assign in_tok = {operator, TOK_W'(in)};
  assign idx = mode_q ? k_q : len_q - LW'(1) - k_q;
  assign cur = tok_q[idx];
  assign op = cur.value[1:0];
  assign a = mode_q ? nxt : top;
  assign b = mode_q ? top : nxt;
  assign res = op == OP_ADD ? a + b : op == OP_SUB ? a - b : a * b;
  always_comb begin
    state_d = state_q;
    tok_d = tok_q;
    len_d = len_q;
    k_d = k_q;
    mode_d = mode_q;
    err_d = err_q;
    push = 1'b0;
    pop2 = 1'b0;
    wdata = '0;
    case (state_q)
      IDLE: if (in_valid) begin
        tok_d[0] = in_tok;
        len_d = LW'(1);
        k_d = '0;
        mode_d = mode;
        err_d = 1'b0;
        state_d = LOAD;
      end
      LOAD: if (!in_valid) state_d = EVAL;
        else if (len_q == LW'(MAX_LEN)) err_d = 1'b1;
        else begin
          tok_d[len_q] = in_tok;
          len_d = len_q + LW'(1);
        end
      EVAL: begin
        if (!cur.operator) begin
          push = 1'b1;
          wdata = OUT_W'(cur.value);
        end else if (op == OP_RSV) err_d = 1'b1;
        else begin
          pop2 = 1'b1;
          wdata = res;
        end
        k_d = k_q + LW'(1);
        state_d = k_q == len_q - LW'(1) ? DONE : EVAL;
      end
      default: begin
        len_d = '0;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      len_q <= '0;
      k_q <= '0;
      mode_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q <= len_d;
      k_q <= k_d;
      mode_q <= mode_d;
      err_q <= err_d | udf | ovf;
    end
    tok_q <= tok_d;
  end
  pn_stack #(.OUT_W(OUT_W), .MAX_LEN(MAX_LEN)) u_stack (
    .clk(clk), .rst(rst), .clr(state_q == DONE), .push(push), .pop2(pop2), .wdata(wdata),
    .top(top), .nxt(nxt), .depth(depth), .udf(udf), .ovf(ovf)
  );
  assign out_valid = state_q == DONE;
  assign fin_err = err_q || depth != LW'(1);
  assign err = out_valid && fin_err;
  assign out = out_valid && !fin_err ? top : '0;
endmodule

// File: tb/tb_pn_eval.sv
// tb_pn_eval: random and directed PN expressions checked against a queue-based evaluator
module tb_pn_eval;
  typedef struct {bit op; int unsigned v;} tb_tok_t;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, op_i = 1'b0, mode = 1'b0;
  logic [2:0] din = '0;
  logic ov, err64, ov8, err8;
  logic [63:0] out64;
  logic [7:0] out8;
  int n_chk = 0, n_fail = 0;
  tb_tok_t q[$];
  always #5 clk = ~clk;
  pn_eval dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(din), .operator(op_i), .mode(mode),
    .out_valid(ov), .out(out64), .err(err64)
  );
  pn_eval #(.OUT_W(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(din), .operator(op_i), .mode(mode),
    .out_valid(ov8), .out(out8), .err(err8)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic put(input bit o, input int unsigned v);
    tb_tok_t tk;
    tk.op = o;
    tk.v = v;
    q.push_back(tk);
  endtask
  function automatic logic [64:0] ref_eval(input bit m);
    longint unsigned st[$];
    longint unsigned x, y, a, b;
    bit e;
    int n;
    tb_tok_t tk;
    n = q.size() > 20 ? 20 : q.size();
    e = q.size() > 20;
    for (int j = 0; j < n; j++) begin
      tk = q[m ? j : n - 1 - j];
      if (!tk.op) st.push_back(longint'(tk.v));
      else if ((tk.v & 3) == 3 || st.size() < 2) e = 1;
      else begin
        x = st.pop_back();
        y = st.pop_back();
        a = m ? y : x;
        b = m ? x : y;
        st.push_back((tk.v & 3) == 0 ? a + b : (tk.v & 3) == 1 ? a - b : a * b);
      end
    end
    if (st.size() != 1) e = 1;
    return e ? {1'b1, 64'd0} : {1'b0, st[0]};
  endfunction
  task automatic gen(input bit m);
    int d, len, p;
    tb_tok_t tk;
    q.delete();
    d = 0;
    len = $urandom_range(1, 16);
    while (q.size() < len) begin
      if (d >= 2 && $urandom_range(0, 1) == 1) begin
        put(1, $urandom_range(0, 2) + 4 * $urandom_range(0, 1));
        d--;
      end else begin
        put(0, $urandom_range(0, 7));
        d++;
      end
    end
    while (d > 1) begin
      put(1, $urandom_range(0, 2));
      d--;
    end
    if ($urandom_range(0, 5) == 0) begin
      p = $urandom_range(0, q.size() - 1);
      tk = q[p];
      tk.op = !tk.op;
      q[p] = tk;
    end
    if ($urandom_range(0, 9) == 0) repeat (22) put(0, $urandom_range(0, 7));
    if (!m) q.reverse();
  endtask
  task automatic run(input bit m, input string tag, input bit dir, input bit e_err, input logic [63:0] e_val);
    logic [64:0] r;
    int c, n;
    bit zok;
    r = dir ? {e_err, e_err ? 64'd0 : e_val} : ref_eval(m);
    n = q.size() > 20 ? 20 : q.size();
    for (int i = 0; i < q.size(); i++) begin
      in_valid = 1'b1;
      op_i = q[i].op;
      mode = i == 0 ? m : 1'($urandom);
      din = 3'(q[i].v);
      @(negedge clk);
    end
    in_valid = 1'b0;
    mode = 1'($urandom);
    c = 0;
    zok = 1;
    while (c < 100) begin
      @(negedge clk);
      c++;
      if (ov) break;
      if (out64 != 0 || out8 != 0 || err64 || ov8) zok = 0;
    end
    chk({tag, "_lat"}, 64'(c), 64'(n + 1));
    chk({tag, "_err"}, {63'd0, err64}, {63'd0, r[64]});
    chk({tag, "_out"}, out64, r[63:0]);
    chk({tag, "_v8"}, {63'd0, ov8}, 64'd1);
    chk({tag, "_err8"}, {63'd0, err8}, {63'd0, r[64]});
    chk({tag, "_out8"}, {56'd0, out8}, {56'd0, r[7:0]});
    chk({tag, "_idle0"}, {63'd0, zok}, 64'd1);
    @(negedge clk);
    chk({tag, "_pulse"}, {62'd0, ov, ov8}, 64'd0);
  endtask
  task automatic watch_none(input string tag, input int cyc);
    bit seen;
    seen = 0;
    repeat (cyc) begin
      @(negedge clk);
      if (ov || ov8) seen = 1;
    end
    chk(tag, {63'd0, seen}, 64'd0);
  endtask
  initial begin
    bit m;
    repeat (3) @(negedge clk);
    chk("rst_ov", {62'd0, ov, ov8}, 64'd0);
    chk("rst_out", out64, 64'd0);
    chk("rst_err", {62'd0, err64, err8}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    q.delete(); put(0, 3); put(0, 4); put(1, 0); put(0, 2); put(1, 2);
    run(1, "pf14", 1, 0, 64'd14);
    q.delete(); put(1, 1); put(0, 1); put(1, 2); put(0, 2); put(0, 3);
    run(0, "pre_m5", 1, 0, 64'hFFFF_FFFF_FFFF_FFFB);
    q.delete(); put(0, 3); put(1, 0);
    run(1, "udf", 1, 1, 64'd0);
    q.delete(); put(0, 1); put(0, 2);
    run(1, "left", 1, 1, 64'd0);
    q.delete();
    repeat (21) put($urandom_range(0, 1), $urandom_range(0, 7));
    run(1, "ovf", 1, 1, 64'd0);
    q.delete(); put(0, 7);
    run(0, "single7", 1, 0, 64'd7);
    q.delete(); put(0, 7); put(0, 7); put(1, 2); put(0, 7); put(1, 2); put(0, 7); put(1, 2);
    run(1, "wrap", 1, 0, 64'd2401);
    for (int p = 0; p < 5; p++) begin
      q.delete(); put(0, 1); put(0, 2); put(1, 0); put(0, 3); put(1, 2);
      q[p] = '{op: 1'b1, v: 3};
      run(1, $sformatf("rsv%0d", p), 1, 1, 64'd0);
    end
    q.delete();
    put(0, 1); put(0, 2); put(1, 0); put(0, 3); put(1, 0); put(0, 4); put(1, 0); put(0, 5); put(1, 0); put(0, 6);
    for (int i = 0; i < q.size(); i++) begin
      in_valid = 1'b1;
      op_i = q[i].op;
      mode = 1'b1;
      din = 3'(q[i].v);
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    watch_none("rst_abort", 30);
    rst = 1'b1;
    in_valid = 1'b1;
    op_i = 1'b0;
    din = 3'd3;
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    watch_none("rst_tok_drop", 10);
    q.delete(); put(0, 5);
    run(1, "after_rst5", 1, 0, 64'd5);
    for (int k = 0; k < 40; k++) begin
      m = 1'($urandom);
      gen(m);
      run(m, $sformatf("rnd%0d", k), 0, 0, 64'd0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
